// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - writeback arbiter merging ALU results and buffered LSU loads into the register file
module wb_arbiter #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    output logic [31:0]     pend_mask,
    output logic            w_ena,
    output logic [4:0]      w_addr,
    output logic [XLEN-1:0] w_data
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // LSU result storage; contents are only meaningful below count, so no reset
    logic [4:0]      fifo_rd   [DEPTH];
    logic [XLEN-1:0] fifo_data [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;

    logic            push;
    logic            pop;
    logic [4:0]      head_rd;
    logic [XLEN-1:0] head_data;

    logic            cand_valid;
    logic [4:0]      cand_rd;
    logic [XLEN-1:0] cand_data;

    logic [31:0]     set_mask;
    logic [31:0]     clr_mask;
    logic [31:0]     pend_q;

    // Ready comes only from the registered count, so a same-cycle pop never frees a slot
    assign lsu_ready = rst_n & (count != FULL);

    assign head_rd   = fifo_rd[rd_ptr];
    assign head_data = fifo_data[rd_ptr];

    // A handshake during flush is dropped; the head is never popped while ALU owns the port or on flush
    assign push = lsu_valid & lsu_ready & ~flush;
    assign pop  = ~alu_valid & (count != '0) & ~flush;

    // Pick the single writeback candidate: ALU first, else the FIFO head being popped
    always_comb begin
        cand_valid = 1'b0;
        cand_rd    = '0;
        cand_data  = '0;
        if (alu_valid) begin
            cand_valid = 1'b1;
            cand_rd    = alu_rd;
            cand_data  = alu_data;
        end else if (pop) begin
            cand_valid = 1'b1;
            cand_rd    = head_rd;
            cand_data  = head_data;
        end
    end

    // One-hot set/clear masks for the pending-load scoreboard; x0 is never tracked
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (issue_valid && (issue_rd != 5'd0)) begin
            set_mask[issue_rd] = 1'b1;
        end
        if (pop && (head_rd != 5'd0)) begin
            clr_mask[head_rd] = 1'b1;
        end
    end

    // Capture accepted LSU results at the write pointer
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_ptr]   <= lsu_rd;
            fifo_data[wr_ptr] <= lsu_data;
        end
    end

    // Pointer and occupancy bookkeeping; flush and reset both empty the FIFO
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Registered write port; address/data hold when there is nothing to write
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_ena  <= 1'b0;
            w_addr <= '0;
            w_data <= '0;
        end else if (cand_valid) begin
            w_ena  <= (cand_rd != 5'd0);
            w_addr <= cand_rd;
            w_data <= cand_data;
        end else begin
            w_ena  <= 1'b0;
        end
    end

    // Scoreboard update: a new issue to the same register outranks the retiring load
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            pend_q <= '0;
        end else begin
            pend_q <= (pend_q & ~clr_mask) | set_mask;
        end
    end

    assign pend_mask = pend_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - self-checking bench for wb_arbiter
module tb_wb_arbiter;

    localparam int DEPTH = 2;
    localparam int XLEN  = 64;

    logic            clk = 1'b0;
    logic            rst_n, flush, alu_valid, lsu_valid, lsu_ready, issue_valid, w_ena;
    logic [4:0]      alu_rd, lsu_rd, issue_rd, w_addr;
    logic [XLEN-1:0] alu_data, lsu_data, w_data;
    logic [31:0]     pend_mask;

    wb_arbiter #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .pend_mask(pend_mask),
        .w_ena(w_ena), .w_addr(w_addr), .w_data(w_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n, flush, av;
        logic [4:0]  ard;
        logic [63:0] adat;
        logic        lv;
        logic [4:0]  lrd;
        logic [63:0] ldat;
        logic        iv;
        logic [4:0]  ird;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic        rdy, we;
        logic [4:0]  wa;
        logic [63:0] wd;
        logic [31:0] pend;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: a queue of buffered loads and a per-register pending array
    logic [4:0]  q_rd[$];
    logic [63:0] q_dat[$];
    logic [31:0] m_pend = '0;
    logic        m_we = 1'b0;
    logic [4:0]  m_wa = '0;
    logic [63:0] m_wd = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic model_ready(input stim_t s);
        return s.rst_n && (q_rd.size() < DEPTH);
    endfunction

    task automatic model_step(input stim_t s);
        logic        acc, have, popped;
        logic [4:0]  crd;
        logic [63:0] cdat;
        if (!s.rst_n) begin
            q_rd.delete(); q_dat.delete();
            m_pend = '0; m_we = 0; m_wa = '0; m_wd = '0;
            return;
        end
        acc = s.lv && (q_rd.size() < DEPTH) && !s.flush;
        have = 0; popped = 0; crd = '0; cdat = '0;
        if (s.av) begin
            have = 1; crd = s.ard; cdat = s.adat;
        end else if (!s.flush && q_rd.size() > 0) begin
            have = 1; popped = 1;
            crd = q_rd.pop_front(); cdat = q_dat.pop_front();
        end
        m_we = have && (crd != 0);
        if (have) begin
            m_wa = crd; m_wd = cdat;
        end
        if (s.flush) begin
            q_rd.delete(); q_dat.delete(); m_pend = '0;
        end else begin
            if (popped && crd != 0) m_pend[crd] = 1'b0;
            if (s.iv && s.ird != 0) m_pend[s.ird] = 1'b1;
            if (acc) begin
                q_rd.push_back(s.lrd); q_dat.push_back(s.ldat);
            end
        end
    endtask

    // Drive one cycle of stimulus, check ready before the edge and all outputs after it
    task automatic do_cycle(input stim_t s, input string tag, output logic rdy_seen);
        @(negedge clk);
        rst_n = s.rst_n; flush = s.flush;
        alu_valid = s.av; alu_rd = s.ard; alu_data = s.adat;
        lsu_valid = s.lv; lsu_rd = s.lrd; lsu_data = s.ldat;
        issue_valid = s.iv; issue_rd = s.ird;
        assert (!(s.rst_n && !s.flush && s.iv && s.ird != 0 && m_pend[s.ird]))
            else $error("stimulus issued a load to a pending register");
        #1;
        rdy_seen = lsu_ready;
        chk({tag, "_ready"}, lsu_ready, model_ready(s));
        @(posedge clk);
        model_step(s);
        #1;
        chk({tag, "_w_ena"}, w_ena, m_we);
        chk({tag, "_w_addr"}, w_addr, m_wa);
        chk({tag, "_w_data"}, w_data, m_wd);
        chk({tag, "_pend"}, pend_mask, m_pend);
    endtask

    function automatic vec_t mk(input logic r, f, av, input logic [4:0] ard, input logic [63:0] adat,
                                input logic lv, input logic [4:0] lrd, input logic [63:0] ldat,
                                input logic iv, input logic [4:0] ird,
                                input logic rdy, we, input logic [4:0] wa, input logic [63:0] wd,
                                input logic [31:0] pend);
        vec_t v;
        v.s.rst_n = r; v.s.flush = f; v.s.av = av; v.s.ard = ard; v.s.adat = adat;
        v.s.lv = lv; v.s.lrd = lrd; v.s.ldat = ldat; v.s.iv = iv; v.s.ird = ird;
        v.rdy = rdy; v.we = we; v.wa = wa; v.wd = wd; v.pend = pend;
        return v;
    endfunction

    vec_t tbl[29];

    initial begin
        logic  rdy;
        stim_t s;
        int    next_rd;
        bit    filled;
        logic [4:0] got[$];

        //            r f av ard adat          lv lrd ldat           iv ird  rdy we wa wd             pend
        tbl[0]  = mk(0,0,0, 0, 0,             0, 0, 0,             0, 0,   0,0, 0, 0,             0);
        tbl[1]  = mk(1,0,0, 0, 0,             0, 0, 0,             0, 0,   1,0, 0, 0,             0);
        tbl[2]  = mk(1,0,1, 5, 64'h1234,      0, 0, 0,             0, 0,   1,1, 5, 64'h1234,      0);
        tbl[3]  = mk(1,0,0, 0, 0,             0, 0, 0,             1, 7,   1,0, 5, 64'h1234,      32'h80);
        tbl[4]  = mk(1,0,0, 0, 0,             1, 7, 64'hDEAD_BEEF, 0, 0,   1,0, 5, 64'h1234,      32'h80);
        tbl[5]  = mk(1,0,0, 0, 0,             0, 0, 0,             0, 0,   1,1, 7, 64'hDEAD_BEEF, 0);
        tbl[6]  = mk(1,0,0, 0, 0,             0, 0, 0,             0, 0,   1,0, 7, 64'hDEAD_BEEF, 0);
        tbl[7]  = mk(1,0,0, 0, 0,             1, 3, 64'h33,        0, 0,   1,0, 7, 64'hDEAD_BEEF, 0);
        tbl[8]  = mk(1,0,1,10, 64'hA0,        0, 0, 0,             0, 0,   1,1,10, 64'hA0,        0);
        tbl[9]  = mk(1,0,1,11, 64'hB0,        1, 4, 64'h44,        0, 0,   1,1,11, 64'hB0,        0);
        tbl[10] = mk(1,0,1,12, 64'hC0,        1, 6, 64'h66,        0, 0,   0,1,12, 64'hC0,        0);
        tbl[11] = mk(1,0,0, 0, 0,             0, 0, 0,             0, 0,   0,1, 3, 64'h33,        0);
        tbl[12] = mk(1,0,0, 0, 0,             0, 0, 0,             0, 0,   1,1, 4, 64'h44,        0);
        tbl[13] = mk(1,0,0, 0, 0,             0, 0, 0,             0, 0,   1,0, 4, 64'h44,        0);
        tbl[14] = mk(1,0,0, 0, 0,             1, 9, 64'h99,        0, 0,   1,0, 4, 64'h44,        0);
        tbl[15] = mk(1,0,0, 0, 0,             1, 0, 64'h55,        1, 9,   1,1, 9, 64'h99,        32'h200);
        tbl[16] = mk(1,0,0, 0, 0,             0, 0, 0,             0, 0,   1,0, 0, 64'h55,        32'h200);
        tbl[17] = mk(1,0,0, 0, 0,             0, 0, 0,             0, 0,   1,0, 0, 64'h55,        32'h200);
        tbl[18] = mk(1,1,1, 2, 64'h22,        0, 0, 0,             0, 0,   1,1, 2, 64'h22,        0);
        tbl[19] = mk(1,0,1, 1, 64'h11,        0, 0, 0,             1, 7,   1,1, 1, 64'h11,        32'h80);
        tbl[20] = mk(1,0,1, 1, 64'h12,        1, 7, 64'h77,        1, 8,   1,1, 1, 64'h12,        32'h180);
        tbl[21] = mk(1,0,1, 1, 64'h13,        1, 8, 64'h88,        0, 0,   1,1, 1, 64'h13,        32'h180);
        tbl[22] = mk(1,1,0, 0, 0,             0, 0, 0,             1, 9,   0,0, 1, 64'h13,        0);
        tbl[23] = mk(1,1,0, 0, 0,             1, 5, 64'h5,         0, 0,   1,0, 1, 64'h13,        0);
        tbl[24] = mk(1,0,0, 0, 0,             0, 0, 0,             0, 0,   1,0, 1, 64'h13,        0);
        tbl[25] = mk(1,0,0, 0, 0,             0, 0, 0,             0, 0,   1,0, 1, 64'h13,        0);
        tbl[26] = mk(1,0,0, 0, 0,             1,12, 64'hCC,        1,12,   1,0, 1, 64'h13,        32'h1000);
        tbl[27] = mk(0,0,1, 3, 64'h3,         1,14, 64'hEE,        0, 0,   0,0, 0, 0,             0);
        tbl[28] = mk(1,0,0, 0, 0,             0, 0, 0,             0, 0,   1,0, 0, 0,             0);

        for (int i = 0; i < 29; i++) begin
            do_cycle(tbl[i].s, $sformatf("vec%0d", i), rdy);
            chk($sformatf("tbl%0d_ready", i), rdy, tbl[i].rdy);
            chk($sformatf("tbl%0d_w_ena", i), w_ena, tbl[i].we);
            chk($sformatf("tbl%0d_w_addr", i), w_addr, tbl[i].wa);
            chk($sformatf("tbl%0d_w_data", i), w_data, tbl[i].wd);
            chk($sformatf("tbl%0d_pend", i), pend_mask, tbl[i].pend);
        end

        // Fill/wrap: ALU (rd 20) stays busy until the FIFO fills, then loads 1..5 drain in order
        next_rd = 1;
        filled  = 0;
        for (int cyc = 0; cyc < 40 && got.size() < 5; cyc++) begin
            s = '{rst_n: 1, flush: 0, av: !filled, ard: 20, adat: 64'(cyc),
                  lv: (next_rd <= 5), lrd: 5'(next_rd), ldat: 64'(next_rd * 'h111),
                  iv: 0, ird: 0};
            if (s.lv && model_ready(s)) next_rd++;
            do_cycle(s, $sformatf("wrap%0d", cyc), rdy);
            if (w_ena && w_addr != 5'd20) got.push_back(w_addr);
            if (!filled && q_rd.size() == DEPTH) begin
                filled = 1;
                #1 chk("wrap_full_ready", lsu_ready, 1'b0);
            end
        end
        chk("wrap_write_count", got.size(), 5);
        for (int i = 0; i < got.size() && i < 5; i++)
            chk($sformatf("wrap_order%0d", i), got[i], 64'(i + 1));

        // Randomized traffic against the model, with occasional flush and reset
        for (int cyc = 0; cyc < 600; cyc++) begin
            s.rst_n = ($urandom_range(0, 99) != 0);
            s.flush = ($urandom_range(0, 24) == 0);
            s.av    = $urandom_range(0, 1) == 1;
            s.ard   = 5'($urandom_range(0, 31));
            s.adat  = {$urandom(), $urandom()};
            s.lv    = $urandom_range(0, 9) < 6;
            s.lrd   = 5'($urandom_range(0, 31));
            s.ldat  = {$urandom(), $urandom()};
            s.ird   = 5'($urandom_range(0, 31));
            s.iv    = ($urandom_range(0, 9) < 3) && !m_pend[s.ird];
            do_cycle(s, $sformatf("rnd%0d", cyc), rdy);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
